// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad matrix emulator.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_BOUNCE,
        ST_HOLD,
        ST_REL_BOUNCE,
        ST_DONE
    } kp_state_e;

    // Bounce generator: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
    // Feedback is the XOR of register bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Key code layout: {row[1:0], col[1:0]}.
    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Press-command handshake between a test driver and the keypad emulator.
interface keypad_emulator_if #(
    parameter int HOLD_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_key;
    logic [HOLD_W-1:0] cmd_hold;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/bounce_lfsr.sv
// Free-running LFSR that supplies the random contact value during bounce phases.
module bounce_lfsr
    import keypad_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    output logic bounce_next
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next LFSR value; bit 0 of it is what the register holds during the next cycle.
    always_comb begin
        lfsr_d      = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        bounce_next = lfsr_d[0];
    end

    // Advance every cycle regardless of emulator state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
endmodule

// File: rtl/keypad_emulator.sv
// Emulates one switch of a passive 4x4 key matrix: press bounce, hold, release bounce.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 16,
    parameter int HOLD_W        = 16
) (
    input  logic             clk,
    input  logic             nrst,
    keypad_emulator_if.slave cmd,
    input  logic [3:0]       col_in,
    output logic [3:0]       row_out,
    output logic             busy,
    output logic             done
);
    localparam int BC_W  = $clog2(BOUNCE_CYCLES + 1);
    localparam int CNT_W = (HOLD_W > BC_W) ? HOLD_W : BC_W;
    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
    localparam logic [CNT_W-1:0] BOUNCE_LAST =
        HAS_BOUNCE ? CNT_W'(BOUNCE_CYCLES - 1) : '0;

    // Phase counters count down to zero; a hold of 0 is stretched to 1 cycle.
    function automatic logic [CNT_W-1:0] hold_last(input logic [HOLD_W-1:0] h);
        logic [CNT_W-1:0] h_ext;
        h_ext = CNT_W'(h);
        return (h == '0) ? '0 : h_ext - CNT_W'(1);
    endfunction

    kp_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        key_q, key_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              contact_q, contact_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bounce_next;

    bounce_lfsr u_lfsr (
        .clk         (clk),
        .nrst        (nrst),
        .bounce_next (bounce_next)
    );

    // Next-state logic; registered outputs are decoded from the next state so they
    // line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid && !busy_q) begin
                    key_d  = cmd.cmd_key;
                    hold_d = cmd.cmd_hold;
                    if (HAS_BOUNCE) begin
                        state_d = ST_PRESS_BOUNCE;
                        cnt_d   = BOUNCE_LAST;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = hold_last(cmd.cmd_hold);
                    end
                end
            end
            ST_PRESS_BOUNCE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = hold_last(hold_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (HAS_BOUNCE) begin
                        state_d = ST_REL_BOUNCE;
                        cnt_d   = BOUNCE_LAST;
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REL_BOUNCE: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            ST_PRESS_BOUNCE, ST_REL_BOUNCE: contact_d = bounce_next;
            ST_HOLD:                        contact_d = 1'b1;
            default:                        contact_d = 1'b0;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            key_q     <= '0;
            hold_q    <= '0;
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            contact_q <= contact_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Passive switch: the selected row follows the selected column while closed.
    always_comb begin
        row_out = '0;
        row_out[key_row(key_q)] = contact_q & col_in[key_col(key_q)];
    end

    assign cmd.cmd_ready = ~busy_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: one instance without bounce, one with 16-cycle bounce.
module tb_keypad_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic [3:0] col0, col16, row0, row16;
    logic       busy0, busy16, done0, done16;

    keypad_emulator_if #(.HOLD_W(16)) if0 ();
    keypad_emulator_if #(.HOLD_W(16)) if16 ();

    keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_W(16)) dut0 (
        .clk(clk), .nrst(nrst), .cmd(if0), .col_in(col0),
        .row_out(row0), .busy(busy0), .done(done0)
    );

    keypad_emulator #(.BOUNCE_CYCLES(16), .HOLD_W(16)) dut16 (
        .clk(clk), .nrst(nrst), .cmd(if16), .col_in(col16),
        .row_out(row16), .busy(busy16), .done(done16)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int q0[$];
    int q16[$];
    int e0, e16;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, advancing every cycle.
    logic [7:0] m;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) m <= 8'hA5;
        else       m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest expected done cycle.
    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            if (done0 === 1'b1) begin
                if (q0.size() == 0) chk("done0_unexpected", {31'd0, done0}, 32'd0);
                else begin
                    e0 = q0.pop_front();
                    chk("done0_cycle", cyc, e0);
                end
            end
            if (done16 === 1'b1) begin
                if (q16.size() == 0) chk("done16_unexpected", {31'd0, done16}, 32'd0);
                else begin
                    e16 = q16.pop_front();
                    chk("done16_cycle", cyc, e16);
                end
            end
        end
    end

    // Drive a command; expected done cycle is pushed at the acceptance cycle.
    task automatic issue(input int which, input logic [3:0] k, input logic [15:0] h,
                         input bit keep, output int c0);
        int n;
        int hl;
        logic rdy;
        @(negedge clk);
        if (which == 0) begin
            if0.cmd_valid = 1'b1; if0.cmd_key = k; if0.cmd_hold = h;
        end else begin
            if16.cmd_valid = 1'b1; if16.cmd_key = k; if16.cmd_hold = h;
        end
        n = 0;
        rdy = (which == 0) ? if0.cmd_ready : if16.cmd_ready;
        while (rdy !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            rdy = (which == 0) ? if0.cmd_ready : if16.cmd_ready;
        end
        chk("accept_ready", {31'd0, rdy}, 32'd1);
        c0 = cyc;
        hl = (h == 16'd0) ? 1 : int'(h);
        if (which == 0) q0.push_back(c0 + hl + 1);
        else            q16.push_back(c0 + 32 + hl + 1);
        @(posedge clk);
        #1;
        if (!keep) begin
            if (which == 0) if0.cmd_valid = 1'b0;
            else            if16.cmd_valid = 1'b0;
        end
    endtask

    typedef struct {
        logic [3:0]  key;
        logic [15:0] hold;
        logic [3:0]  col;
        logic [3:0]  exp_row;
    } vec_t;

    vec_t vt [9];

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, ca, cb, n, hl;
        logic expb;

        vt[0] = '{4'h6, 16'd4, 4'b0100, 4'b0010};
        vt[1] = '{4'h6, 16'd3, 4'b0001, 4'b0000};
        vt[2] = '{4'h6, 16'd3, 4'b1111, 4'b0010};
        vt[3] = '{4'h0, 16'd2, 4'b0001, 4'b0001};
        vt[4] = '{4'hF, 16'd2, 4'b1000, 4'b1000};
        vt[5] = '{4'hF, 16'd1, 4'b1111, 4'b1000};
        vt[6] = '{4'h9, 16'd5, 4'b0010, 4'b0100};
        vt[7] = '{4'h3, 16'd0, 4'b1000, 4'b0001};
        vt[8] = '{4'hC, 16'd2, 4'b0001, 4'b1000};

        if0.cmd_valid = 1'b0;  if0.cmd_key = 4'h0;  if0.cmd_hold = 16'd0;
        if16.cmd_valid = 1'b0; if16.cmd_key = 4'h0; if16.cmd_hold = 16'd0;
        col0 = 4'b1111;
        col16 = 4'b1111;
        nrst = 1'b0;

        // Reset state, before any clock edge.
        #1;
        chk("rst_row0", {28'd0, row0}, 32'd0);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_ready0", {31'd0, if0.cmd_ready}, 32'd1);
        chk("rst_done0", {31'd0, done0}, 32'd0);
        chk("rst_row16", {28'd0, row16}, 32'd0);
        chk("rst_ready16", {31'd0, if16.cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Table: hold phase row behaviour and exact hold length, no bounce.
        for (int i = 0; i < 9; i++) begin
            col0 = vt[i].col;
            issue(0, vt[i].key, vt[i].hold, 1'b0, c);
            hl = (vt[i].hold == 16'd0) ? 1 : int'(vt[i].hold);
            for (int j = 0; j < hl; j++) begin
                @(negedge clk);
                chk($sformatf("vec%0d_hold_row", i), {28'd0, row0}, {28'd0, vt[i].exp_row});
                chk($sformatf("vec%0d_hold_busy", i), {31'd0, busy0}, 32'd1);
            end
            @(negedge clk);
            chk($sformatf("vec%0d_done_row", i), {28'd0, row0}, 32'd0);
        end

        // Column changes during hold propagate in the same cycle.
        col0 = 4'b0100;
        issue(0, 4'h6, 16'd6, 1'b0, c);
        @(negedge clk);
        chk("comb_row_base", {28'd0, row0}, 32'b0010);
        col0 = 4'b0001;
        #1 chk("comb_row_other_col", {28'd0, row0}, 32'b0000);
        col0 = 4'b1111;
        #1 chk("comb_row_all_cols", {28'd0, row0}, 32'b0010);
        col0 = 4'b0100;
        for (int j = 2; j <= 6; j++) begin
            @(negedge clk);
            chk("comb_row_rest", {28'd0, row0}, 32'b0010);
        end
        @(negedge clk);

        // Command held during busy is ignored, then accepted right after done.
        col0 = 4'b0100;
        issue(0, 4'h6, 16'd4, 1'b0, ca);
        if0.cmd_valid = 1'b1; if0.cmd_key = 4'hF; if0.cmd_hold = 16'd3;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk("busy_ready_low", {31'd0, if0.cmd_ready}, 32'd0);
            chk("busy_row_key6", {28'd0, row0}, (j <= 4) ? 32'b0010 : 32'b0000);
        end
        issue(0, 4'hF, 16'd3, 1'b0, cb);
        chk("busy_accept_cycle", cb, ca + 6);
        col0 = 4'b1000;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("keyF_row", {28'd0, row0}, 32'b1000);
        end
        @(negedge clk);

        // Bounce on the 16-cycle instance follows the reference LFSR.
        col16 = 4'b0001;
        issue(1, 4'h0, 16'd10, 1'b0, c);
        for (int j = 1; j <= 42; j++) begin
            @(negedge clk);
            expb = (j <= 16 || j > 26) ? m[0] : 1'b1;
            chk($sformatf("b16_row_c%0d", j), {28'd0, row16}, {31'd0, expb});
        end
        @(negedge clk);
        chk("b16_done_row", {28'd0, row16}, 32'd0);

        // Reset mid-hold abandons the command.
        col0 = 4'b0100;
        issue(0, 4'h6, 16'd8, 1'b0, c);
        repeat (3) begin
            @(negedge clk);
            chk("pre_rst_row", {28'd0, row0}, 32'b0010);
        end
        #2 nrst = 1'b0;
        q0.delete();
        #1;
        chk("midrst_row", {28'd0, row0}, 32'd0);
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_ready", {31'd0, if0.cmd_ready}, 32'd1);
        chk("midrst_done", {31'd0, done0}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("in_rst_row", {28'd0, row0}, 32'd0);
            chk("in_rst_done", {31'd0, done0}, 32'd0);
        end
        nrst = 1'b1;
        issue(0, 4'h6, 16'd2, 1'b0, c);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("post_rst_row", {28'd0, row0}, 32'b0010);
        end
        @(negedge clk);
        chk("post_rst_done_row", {28'd0, row0}, 32'd0);

        // Let outstanding done pulses arrive.
        n = 0;
        while ((q0.size() + q16.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", q0.size() + q16.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 16: number of cycles in each of the press and release bounce phases; 0 disables bounce.
REQ-002 Parameter HOLD_W, default 16: width of the hold-duration command field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  press command present.
REQ-006 cmd_ready  output  1  emulator can accept a command.
REQ-007 cmd_key  input  4  key code; row index = cmd_key[3:2], column index = cmd_key[1:0].
REQ-008 cmd_hold  input  HOLD_W  stable-closed duration in cycles.
REQ-009 col_in  input  4  active-high column drive from the scanner (one-hot, or 4'b1111 while the scanner is holding).
REQ-010 row_out  output  4  active-high row sense returned to the scanner.
REQ-011 busy  output  1  command in progress.
REQ-012 done  output  1  one-cycle pulse at the end of a command.

Function
REQ-013 The module SHALL model one switch of a passive 4x4 matrix: row_out[r] = contact & col_in[c]; all other row_out bits 0; this path is combinational from col_in and the registered contact.
REQ-014 FSM states SHALL be IDLE, PRESS_BOUNCE, HOLD, REL_BOUNCE, DONE.
REQ-015 IDLE: cmd_ready=1, contact=0; on cmd_valid&cmd_ready, latch key/hold and go to PRESS_BOUNCE (or HOLD if BOUNCE_CYCLES=0).
REQ-016 PRESS_BOUNCE: exactly BOUNCE_CYCLES cycles; contact = LFSR bit 0 each cycle; then HOLD.
REQ-017 HOLD: contact=1 for exactly max(latched hold,1) cycles; then REL_BOUNCE (or DONE if BOUNCE_CYCLES=0).
REQ-018 REL_BOUNCE: exactly BOUNCE_CYCLES cycles, contact = LFSR bit 0; then DONE.
REQ-019 DONE: one cycle, contact=0, done=1; then IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE; cmd_ready = ~busy.
REQ-021 cmd_valid while busy SHALL be ignored; cmd_key/cmd_hold SHALL be sampled only at acceptance.
REQ-022 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every cycle regardless of state.
REQ-023 Phase counter width SHALL cover max(HOLD_W, clog2(BOUNCE_CYCLES+1)) with no wrap; hold=0 treated as 1.
REQ-024 Latency accept-to-done pulse SHALL be 2*BOUNCE_CYCLES + max(hold,1) + 1 cycles.

Reset
REQ-025 On nrst low, asynchronously: state=IDLE, contact=0, LFSR=8'hA5, counters=0, done=0; row_out=0, busy=0, cmd_ready=1 without waiting for a clock.
REQ-026 Reset mid-command SHALL abandon the command; no done pulse is produced for it.

Structure
REQ-027 Package keypad_pkg SHALL hold the state enum, LFSR seed/taps constants and key-to-row/column index helpers.
REQ-028 Sub-module bounce_lfsr SHALL contain the LFSR (outputs the bit-0 bounce value).

Verification
REQ-029 BOUNCE_CYCLES=0, key 4'h6, hold 4, col_in=4'b0100 -> row_out=4'b0010 for exactly 4 cycles, done pulse 5 cycles after acceptance.
REQ-030 During HOLD of key 4'h6: col_in=4'b0001 -> row_out=4'b0000; col_in=4'b1111 -> row_out=4'b0010 in the same cycle.
REQ-031 BOUNCE_CYCLES=16, key 4'h0, hold 10, col_in=4'b0001 -> row_out[0] matches reference LFSR bit-0 sequence during both bounce phases; done 43 cycles after acceptance.
REQ-032 cmd_valid held high with key 4'hF during busy -> not accepted (cmd_ready=0); accepted the cycle after done.
REQ-033 nrst low mid-HOLD -> row_out=0, busy=0 before the next edge; no done pulse; next command runs normally.
REQ-034 hold=0, BOUNCE_CYCLES=0 -> contact closed exactly 1 cycle, done 2 cycles after acceptance.
